output_drain: RTL and testbench



---
 rtl/output_drain_pkg.sv | 30 +++
 rtl/output_drain_skid.sv | 34 +++
 rtl/output_drain.sv | 121 ++++++++++++
 tb/tb_output_drain.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/output_drain_pkg.sv
// Shared state encoding, sizing helper and requantize arithmetic for the output drain.
// RELU_EN: when defined, negative lanes clamp to zero after the shift and before saturation.
package output_drain_pkg;

  typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} drain_state_t;

  // Wide enough for a 2*DATA_WIDTH+1 rounding add for any DATA_WIDTH up to 32.
  localparam int QW = 72;

  function automatic int accum_rows(input int size, input int cols);
    return size / cols;
  endfunction

  function automatic logic signed [QW-1:0] requantize(input logic signed [QW-1:0] value,
                                                      input logic [4:0] shamt,
                                                      input int dw);
    logic signed [QW-1:0] rnd, s, hi, lo;
    rnd = (shamt == 5'd0) ? '0 : (QW'(1) <<< (shamt - 5'd1));
    s = (value + rnd) >>> shamt;
`ifdef RELU_EN
    if (s < QW'(0)) s = '0;
`endif
    hi = (QW'(1) <<< (dw - 1)) - QW'(1);
    lo = -(QW'(1) <<< (dw - 1));
    if (s > hi) s = hi;
    else if (s < lo) s = lo;
    return s;
  endfunction

endpackage

// File: rtl/output_drain_skid.sv
// Two-entry FIFO between the accumulator read return and the output memory write port.
module drain_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [1:0]   count,
  output logic [W-1:0] head
);
  logic [1:0][W-1:0] mem;
  logic              wr_ptr, rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/output_drain.sv
// Drains accumulator rows, requantizes each lane and writes rows to output memory.
// state | meaning: IDLE wait start | READ issue reads | FLUSH empty pipe+skid | DONE pulse done
module output_drain
  import output_drain_pkg::*;
#(
  parameter int SYS_COL    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACCUM_SIZE = 1024,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [DATA_WIDTH-1:0]           num_row,
  input  logic [7:0]                      accum_base,
  input  logic [ADDR_WIDTH-1:0]           out_base,
  input  logic [4:0]                      shamt,
  output logic [SYS_COL-1:0]              accum_rd_en,
  output logic [SYS_COL*8-1:0]            accum_rd_addr,
  input  logic [SYS_COL*2*DATA_WIDTH-1:0] accum_rd_data,
  input  logic                            out_ready,
  output logic [SYS_COL-1:0]              out_wr_en,
  output logic [ADDR_WIDTH-1:0]           out_wr_addr,
  output logic [SYS_COL*DATA_WIDTH-1:0]   out_wr_data,
  output logic                            busy,
  output logic                            done
);
  localparam int ACCUM_ROW = accum_rows(ACCUM_SIZE, SYS_COL);
  localparam int RW = 2 * DATA_WIDTH;
  localparam int LW = SYS_COL * DATA_WIDTH;
  localparam int EW = ADDR_WIDTH + LW;
  localparam logic [7:0] RD_LAST = 8'(ACCUM_ROW - 1);

  drain_state_t state, state_nxt;
  logic [DATA_WIDTH-1:0] num_q, issued_q;
  logic [7:0]            rd_addr_q;
  logic [ADDR_WIDTH-1:0] push_addr_q;
  logic [4:0]            shamt_q;
  logic                  inflight_q;
  logic [1:0]            skid_count;
  logic [EW-1:0]         skid_head;
  logic [LW-1:0]         lanes;
  logic                  pop, room, issue, last_issue;

  // Counting the in-flight read against the skid keeps it from ever overflowing.
  assign pop        = out_ready & (skid_count != 2'd0);
  assign room       = ({1'b0, skid_count} + {2'b00, inflight_q} - {2'b00, pop}) < 3'd2;
  assign issue      = (state == READ) & room;
  assign last_issue = issue & (issued_q == num_q - DATA_WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // An empty drain falls through FLUSH so done keeps its two-cycle minimum latency.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (num_row == '0) ? FLUSH : READ;
      READ:    if (last_issue) state_nxt = FLUSH;
      FLUSH:   if (!inflight_q && (skid_count == {1'b0, pop})) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accum_rd_en = {SYS_COL{issue}};
    out_wr_en   = {SYS_COL{pop}};
    busy        = (state != IDLE);
    done        = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_q       <= '0;
      issued_q    <= '0;
      rd_addr_q   <= '0;
      push_addr_q <= '0;
      shamt_q     <= '0;
      inflight_q  <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        num_q       <= num_row;
        issued_q    <= '0;
        rd_addr_q   <= accum_base;
        push_addr_q <= out_base;
        shamt_q     <= shamt;
      end else begin
        if (issue) begin
          issued_q  <= issued_q + DATA_WIDTH'(1);
          rd_addr_q <= (rd_addr_q == RD_LAST) ? 8'd0 : rd_addr_q + 8'd1;
        end
        if (inflight_q) push_addr_q <= push_addr_q + ADDR_WIDTH'(1);
      end
      inflight_q <= issue;
    end
  end

  always_comb begin
    lanes = '0;
    for (int i = 0; i < SYS_COL; i++)
      lanes[i*DATA_WIDTH +: DATA_WIDTH] =
        DATA_WIDTH'(requantize(QW'($signed(accum_rd_data[i*RW +: RW])), shamt_q, DATA_WIDTH));
  end

  drain_skid #(.W(EW)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .pop   (pop),
    .din   ({push_addr_q, lanes}),
    .count (skid_count),
    .head  (skid_head)
  );

  assign accum_rd_addr              = {SYS_COL{rd_addr_q}};
  assign {out_wr_addr, out_wr_data} = skid_head;

endmodule

// File: tb/tb_output_drain.sv
// Directed self-checking bench for output_drain with accumulator and output memory models.
module tb_output_drain;
  localparam int NC = 4;
  localparam int DW = 16;
  localparam int AW = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [DW-1:0]     num_row = '0;
  logic [7:0]        accum_base = '0;
  logic [AW-1:0]     out_base = '0;
  logic [4:0]        shamt = '0;
  logic [NC-1:0]     accum_rd_en;
  logic [NC*8-1:0]   accum_rd_addr;
  logic [NC*2*DW-1:0] accum_rd_data = '0;
  logic              out_ready = 1'b1;
  logic [NC-1:0]     out_wr_en;
  logic [AW-1:0]     out_wr_addr;
  logic [NC*DW-1:0]  out_wr_data;
  logic              busy, done;

  output_drain #(.SYS_COL(NC), .DATA_WIDTH(DW), .ACCUM_SIZE(1024), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_row(num_row), .accum_base(accum_base),
    .out_base(out_base), .shamt(shamt), .accum_rd_en(accum_rd_en), .accum_rd_addr(accum_rd_addr),
    .accum_rd_data(accum_rd_data), .out_ready(out_ready), .out_wr_en(out_wr_en),
    .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, start_cyc = 0, skid_max = 0, partial_en = 0;
  logic [127:0] acc_mem [256];
  logic [3:0]   bp_pat = 4'b1001;
  int           wr_addr_log[$], rd_addr_log[$], wr_cyc_log[$], rd_cyc_log[$], done_log[$];
  logic [63:0]  wr_data_log[$], exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (accum_rd_en[0]) accum_rd_data <= acc_mem[accum_rd_addr[7:0]];

  always @(negedge clk) begin
    if (!rst) begin
      if (out_wr_en != '0) begin
        wr_addr_log.push_back(int'(out_wr_addr));
        wr_data_log.push_back(out_wr_data);
        wr_cyc_log.push_back(cyc - start_cyc);
        if (out_wr_en != 4'hF) partial_en++;
      end
      if (accum_rd_en != '0) begin
        rd_addr_log.push_back(int'(accum_rd_addr[7:0]));
        rd_cyc_log.push_back(cyc - start_cyc);
      end
      if (done) done_log.push_back(cyc - start_cyc);
      if (int'(dut.u_skid.count) > skid_max) skid_max = int'(dut.u_skid.count);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] exp_row(input int r);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < NC; i++) v[16*i +: 16] = 16'((r << 4) | i);
    return v;
  endfunction

  task automatic fill_generic();
    for (int r = 0; r < 256; r++)
      for (int i = 0; i < NC; i++) acc_mem[r][32*i +: 32] = 32'(((r << 4) | i) << 8);
  endtask

  task automatic start_drain(input int n, input int ab, input int ob, input int sh, input bit bp);
    @(posedge clk); #1;
    wr_addr_log.delete(); wr_data_log.delete(); wr_cyc_log.delete();
    rd_addr_log.delete(); rd_cyc_log.delete(); done_log.delete();
    skid_max = 0; partial_en = 0;
    num_row = DW'(n); accum_base = 8'(ab); out_base = AW'(ob); shamt = 5'(sh);
    out_ready = bp ? bp_pat[0] : 1'b1;
    start = 1'b1;
    start_cyc = cyc;
  endtask

  task automatic run(input int budget, input bit bp, input int restart);
    bit seen;
    int rel;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        rel = cyc - start_cyc;
        start = (rel == restart);
        if (start) begin num_row = 16'd9; accum_base = 8'd100; out_base = 8'd200; shamt = 5'd0; end
        out_ready = bp ? bp_pat[rel % 4] : 1'b1;
      end
    end
    check("done_seen", 64'(seen), 64'd1);
    check("busy_at_done", 64'(busy), 64'd1);
    @(posedge clk); #1;
    check("busy_after_done", 64'(busy), 64'd0);
    check("done_one_cycle", 64'(done), 64'd0);
    out_ready = 1'b1;
  endtask

  task automatic verify(input string tag, input int n, input int ab, input int ob,
                        input bit ck_cyc, input int done_cyc);
    int dc;
    check({tag, "_nwr"}, 64'(wr_addr_log.size()), 64'(n));
    check({tag, "_nrd"}, 64'(rd_addr_log.size()), 64'(n));
    for (int k = 0; k < n && k < wr_addr_log.size(); k++) begin
      check({tag, "_wr_addr"}, 64'(wr_addr_log[k]), 64'((ob + k) % 256));
      check({tag, "_wr_data"}, wr_data_log[k], exp_q[k]);
      if (ck_cyc) check({tag, "_wr_cyc"}, 64'(wr_cyc_log[k]), 64'(3 + k));
    end
    for (int k = 0; k < n && k < rd_addr_log.size(); k++)
      check({tag, "_rd_addr"}, 64'(rd_addr_log[k]), 64'((ab + k) % 256));
    if (ck_cyc && n > 0 && rd_cyc_log.size() > 0) check({tag, "_rd_first"}, 64'(rd_cyc_log[0]), 64'd1);
    check({tag, "_ndone"}, 64'(done_log.size()), 64'd1);
    dc = (done_cyc < 0 && wr_cyc_log.size() > 0) ? wr_cyc_log[wr_cyc_log.size()-1] + 1 : done_cyc;
    check({tag, "_done_cyc"}, 64'(done_log.size() > 0 ? done_log[0] : -1), 64'(dc));
    check({tag, "_partial_en"}, 64'(partial_en), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_rd_en", 64'(accum_rd_en), 64'd0);
    check("rst_rd_addr", 64'(accum_rd_addr), 64'd0);
    check("rst_wr_en", 64'(out_wr_en), 64'd0);
    check("rst_wr_addr", 64'(out_wr_addr), 64'd0);
    check("rst_wr_data", out_wr_data, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);

    // basic drain: rows 0..3 hold 0x100*(row+1)
    for (int r = 0; r < 4; r++) begin
      acc_mem[r] = {4{32'(256 * (r + 1))}};
      exp_q[r] = {4{16'(r + 1)}};
    end
    start_drain(4, 0, 0, 8, 1'b0);
    run(100, 1'b0, -1);
    verify("basic", 4, 0, 0, 1'b1, 7);

    // rounding and saturation, shamt=8
    acc_mem[0] = {32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_017F, 32'h0000_0180};
    acc_mem[1] = {32'hFFFF_FE7F, 32'hFFFF_FE80, 32'h0000_0080, 32'h0000_007F};
    acc_mem[2] = {32'hFFFF_7FFF, 32'h0001_0000, 32'hFFFF_FFFF, 32'h0000_1234};
    exp_q.delete();
`ifdef RELU_EN
    exp_q.push_back({16'h0000, 16'h7FFF, 16'h0001, 16'h0002});
    exp_q.push_back({16'h0000, 16'h0000, 16'h0001, 16'h0000});
`else
    exp_q.push_back({16'h8000, 16'h7FFF, 16'h0001, 16'h0002});
    exp_q.push_back({16'hFFFE, 16'hFFFF, 16'h0001, 16'h0000});
`endif
    start_drain(2, 0, 8, 8, 1'b0);
    run(100, 1'b0, -1);
    verify("round", 2, 0, 8, 1'b1, 5);

    // shamt=0: no rounding, saturation only
    exp_q.delete();
`ifdef RELU_EN
    exp_q.push_back({16'h0000, 16'h7FFF, 16'h0000, 16'h1234});
`else
    exp_q.push_back({16'h8000, 16'h7FFF, 16'hFFFF, 16'h1234});
`endif
    start_drain(1, 2, 30, 0, 1'b0);
    run(100, 1'b0, -1);
    verify("sh0", 1, 2, 30, 1'b1, 4);

    // backpressure with out_ready 1,0,0,1,...
    fill_generic();
    exp_q.delete();
    for (int k = 0; k < 6; k++) exp_q.push_back(exp_row(5 + k));
    start_drain(6, 5, 16, 8, 1'b1);
    run(200, 1'b1, -1);
    verify("bp", 6, 5, 16, 1'b0, -1);
    check("bp_skid_max_le2", 64'(skid_max <= 2), 64'd1);

    // wrap-around of both address spaces
    exp_q.delete();
    for (int k = 0; k < 3; k++) exp_q.push_back(exp_row((254 + k) % 256));
    start_drain(3, 254, 255, 8, 1'b0);
    run(100, 1'b0, -1);
    verify("wrap", 3, 254, 255, 1'b1, 6);

    // empty drain
    start_drain(0, 7, 7, 8, 1'b0);
    run(100, 1'b0, -1);
    check("zero_nwr", 64'(wr_addr_log.size()), 64'd0);
    check("zero_nrd", 64'(rd_addr_log.size()), 64'd0);
    check("zero_done_cyc", 64'(done_log.size() > 0 ? done_log[0] : -1), 64'd2);

    // second start while busy is ignored
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(exp_row(10 + k));
    start_drain(4, 10, 20, 8, 1'b0);
    run(100, 1'b0, 2);
    verify("busy_start", 4, 10, 20, 1'b1, 7);

    // reset during the 3rd write of an 8-row drain
    start_drain(8, 0, 0, 8, 1'b0);
    for (int n = 0; n < 50 && (cyc - start_cyc) < 5; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("mid_wr_en", 64'(out_wr_en), 64'hF);
    check("mid_wr_addr", 64'(out_wr_addr), 64'd2);
    rst = 1'b1;
    #1;
    check("mid_rst_rd_en", 64'(accum_rd_en), 64'd0);
    check("mid_rst_rd_addr", 64'(accum_rd_addr), 64'd0);
    check("mid_rst_wr_en", 64'(out_wr_en), 64'd0);
    check("mid_rst_wr_addr", 64'(out_wr_addr), 64'd0);
    check("mid_rst_wr_data", out_wr_data, 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    done_log.delete();
    wr_addr_log.delete();
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_ndone", 64'(done_log.size()), 64'd0);
    check("post_rst_nwr", 64'(wr_addr_log.size()), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);

    exp_q.delete();
    for (int k = 0; k < 2; k++) exp_q.push_back(exp_row(50 + k));
    start_drain(2, 50, 60, 8, 1'b0);
    run(100, 1'b0, -1);
    verify("fresh", 2, 50, 60, 1'b1, 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
